// File: rtl/forwarding_pipe.sv
// Operand-forwarding select generator with load-use stall detection for a pipelined core.
// Define FWD_ST_EN to forward (and stall on) the store-data source register as well.
module forwarding_pipe #(
   parameter int ADDR_LEN  = 5,
   parameter int FWD_DEPTH = 2,
   parameter int CNT_W     = 16,
   localparam int SEL_W    = $clog2(FWD_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                freeze,
   input  logic                flush,
   input  logic                valid_ID,
   input  logic [ADDR_LEN-1:0] src1_ID,
   input  logic [ADDR_LEN-1:0] src2_ID,
   input  logic [ADDR_LEN-1:0] st_src_ID,
   input  logic [ADDR_LEN-1:0] dest_ID,
   input  logic                WB_EN_ID,
   input  logic                MEM_R_EN_ID,
   output logic [SEL_W-1:0]    val1_sel,
   output logic [SEL_W-1:0]    val2_sel,
   output logic [SEL_W-1:0]    st_sel,
   output logic                hazard_stall,
   output logic [CNT_W-1:0]    stall_cnt
);

   typedef struct packed {
      logic                wb_en;
      logic                mem_r;
      logic [ADDR_LEN-1:0] dest;
   } tag_t;

   typedef tag_t tag_arr_t [FWD_DEPTH+1];

   tag_arr_t         tag_q;
   tag_t             ent0_d;
   logic [SEL_W-1:0] val1_sel_q, val1_sel_d;
   logic [SEL_W-1:0] val2_sel_q, val2_sel_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             ld_hit;
   logic             bubble;

   // Nearest producer wins; the oldest entry is covered by the register file's write-before-read.
   function automatic logic [SEL_W-1:0] nearest_sel(input logic [ADDR_LEN-1:0] src,
                                                    input tag_arr_t tags);
      logic [SEL_W-1:0] sel;
      logic             found;
      sel   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < FWD_DEPTH; k++) begin
         if (!found && (src != '0) && tags[k].wb_en && (tags[k].dest == src)) begin
            sel   = SEL_W'(k + 1);
            found = 1'b1;
         end
      end
      return sel;
   endfunction

   always_comb begin
      ld_hit = tag_q[0].wb_en && tag_q[0].mem_r && (tag_q[0].dest != '0) &&
               ((tag_q[0].dest == src1_ID) || (tag_q[0].dest == src2_ID));
`ifdef FWD_ST_EN
      ld_hit = ld_hit || (tag_q[0].wb_en && tag_q[0].mem_r && (tag_q[0].dest != '0) &&
                          (tag_q[0].dest == st_src_ID));
`endif
      hazard_stall = valid_ID && !flush && ld_hit;
   end

   always_comb begin
      bubble       = !valid_ID || hazard_stall || flush;
      ent0_d.wb_en = WB_EN_ID && !bubble;
      ent0_d.mem_r = MEM_R_EN_ID && !bubble;
      ent0_d.dest  = dest_ID;
      val1_sel_d   = bubble ? '0 : nearest_sel(src1_ID, tag_q);
      val2_sel_d   = bubble ? '0 : nearest_sel(src2_ID, tag_q);
      stall_cnt_d  = stall_cnt_q;
      if (hazard_stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i <= FWD_DEPTH; i++) begin
            tag_q[i] <= '0;
         end
         val1_sel_q  <= '0;
         val2_sel_q  <= '0;
         stall_cnt_q <= '0;
      end else if (!freeze) begin
         for (int unsigned i = FWD_DEPTH; i > 0; i--) begin
            tag_q[i] <= tag_q[i-1];
         end
         tag_q[0]    <= ent0_d;
         val1_sel_q  <= val1_sel_d;
         val2_sel_q  <= val2_sel_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

`ifdef FWD_ST_EN
   logic [SEL_W-1:0] st_sel_q, st_sel_d;

   always_comb begin
      st_sel_d = bubble ? '0 : nearest_sel(st_src_ID, tag_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_sel_q <= '0;
      end else if (!freeze) begin
         st_sel_q <= st_sel_d;
      end
   end

   assign st_sel = st_sel_q;
`else
   logic [ADDR_LEN-1:0] unused_st_src;
   assign unused_st_src = st_src_ID;
   assign st_sel        = '0;
`endif

   assign val1_sel  = val1_sel_q;
   assign val2_sel  = val2_sel_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_pipe.sv
// Scoreboard bench for forwarding_pipe: instruction-history reference model, directed and random traffic.
module tb_forwarding_pipe;

   localparam int D  = 2;
   localparam int AL = 5;
   localparam int CW = 4;
   localparam int SW = $clog2(D + 1);
`ifdef FWD_ST_EN
   localparam bit ST_EN = 1'b1;
`else
   localparam bit ST_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, freeze, flush, valid_ID;
   logic [AL-1:0] src1_ID, src2_ID, st_src_ID, dest_ID;
   logic          WB_EN_ID, MEM_R_EN_ID;
   logic [SW-1:0] val1_sel, val2_sel, st_sel;
   logic          hazard_stall;
   logic [CW-1:0] stall_cnt;

   forwarding_pipe #(.ADDR_LEN(AL), .FWD_DEPTH(D), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .valid_ID(valid_ID),
      .src1_ID(src1_ID), .src2_ID(src2_ID), .st_src_ID(st_src_ID), .dest_ID(dest_ID),
      .WB_EN_ID(WB_EN_ID), .MEM_R_EN_ID(MEM_R_EN_ID),
      .val1_sel(val1_sel), .val2_sel(val2_sel), .st_sel(st_sel),
      .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { bit wb; bit mr; int dest; } instr_t;
   typedef struct { int stall; int s1; int s2; int st; int cnt; } exp_t;

   instr_t hist[$];
   exp_t   expq[$];
   int     m_s1, m_s2, m_st, m_cnt;
   int     n_checks = 0;
   int     n_err = 0;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      hist.delete();
      for (int i = 0; i <= D; i++) hist.push_back('{wb: 1'b0, mr: 1'b0, dest: 0});
      m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0;
   endtask

   // Age of the youngest in-flight writer of s (1 = just left EXE); oldest slot never forwards.
   function automatic int fsel(input int s);
      if (s == 0) return 0;
      for (int k = 0; k < D; k++)
         if (hist[k].wb && hist[k].dest == s) return k + 1;
      return 0;
   endfunction

   task automatic issue(input bit v, input int s1, input int s2, input int st, input int d,
                        input bit wb, input bit mr, input bit fl, input bit fz, output bit stl);
      exp_t   e;
      instr_t ld;
      bit     bub;
      @(negedge clk);
      valid_ID = v; src1_ID = AL'(s1); src2_ID = AL'(s2); st_src_ID = AL'(st);
      dest_ID = AL'(d); WB_EN_ID = wb; MEM_R_EN_ID = mr; flush = fl; freeze = fz;
      ld  = hist[0];
      stl = v && !fl && ld.wb && ld.mr && ld.dest != 0 &&
            (ld.dest == s1 || ld.dest == s2 || (ST_EN && ld.dest == st));
      if (!fz) begin
         bub  = !v || stl || fl;
         m_s1 = bub ? 0 : fsel(s1);
         m_s2 = bub ? 0 : fsel(s2);
         m_st = (bub || !ST_EN) ? 0 : fsel(st);
         if (stl && m_cnt < (1 << CW) - 1) m_cnt++;
         hist.push_front('{wb: wb && !bub, mr: mr && !bub, dest: d});
         void'(hist.pop_back());
      end
      e.stall = stl; e.s1 = m_s1; e.s2 = m_s2; e.st = m_st; e.cnt = m_cnt;
      expq.push_back(e);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_val1_sel"}, val1_sel, 0);
      check({tag, "_val2_sel"}, val2_sel, 0);
      check({tag, "_st_sel"}, st_sel, 0);
      check({tag, "_hazard"}, hazard_stall, 0);
      check({tag, "_stall_cnt"}, stall_cnt, 0);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #3;
      valid_ID = 1'b0; freeze = 1'b1; flush = 1'b0;
      rst = 1'b0;
      #1;
      check_all_zero("midrst");
      model_clear();
      @(negedge clk);
      #1 rst = 1'b1;
   endtask

   // Monitor: hazard is combinational on the current ID inputs; selects/count appear after the edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("hazard_stall", hazard_stall, e.stall);
            @(posedge clk);
            #1;
            check("val1_sel", val1_sel, e.s1);
            check("val2_sel", val2_sel, e.s2);
            check("st_sel", st_sel, e.st);
            check("stall_cnt", stall_cnt, e.cnt);
         end
      end
   end

   initial begin
      bit stl;
      int s1, s2, st, d;
      bit v, wb, mr, fl, fz;
      rst = 1'b0; freeze = 1'b1; flush = 1'b0; valid_ID = 1'b0;
      src1_ID = '0; src2_ID = '0; st_src_ID = '0; dest_ID = '0;
      WB_EN_ID = 1'b0; MEM_R_EN_ID = 1'b0;
      model_clear();
      #2;
      check_all_zero("reset");
      #10 rst = 1'b1;

      // Back-to-back and one-gap forwarding
      issue(1, 1, 2, 0, 3, 1, 0, 0, 0, stl);
      issue(1, 3, 4, 0, 6, 1, 0, 0, 0, stl);
      issue(1, 0, 0, 0, 3, 1, 0, 0, 0, stl);
      issue(1, 1, 1, 0, 9, 1, 0, 0, 0, stl);
      issue(1, 3, 0, 0, 10, 1, 0, 0, 0, stl);
      // Nearest producer among two writers of r3
      issue(1, 0, 0, 0, 3, 1, 0, 0, 0, stl);
      issue(1, 0, 0, 0, 3, 1, 0, 0, 0, stl);
      issue(1, 1, 3, 0, 4, 1, 0, 0, 0, stl);
      // Load-use: stall, then retried consumer forwarded from MEM
      issue(1, 0, 0, 0, 5, 1, 1, 0, 0, stl);
      issue(1, 5, 0, 0, 6, 1, 0, 0, 0, stl);
      issue(1, 5, 0, 0, 6, 1, 0, 0, 0, stl);
      // r0 never matches
      issue(1, 0, 0, 0, 0, 1, 1, 0, 0, stl);
      issue(1, 0, 0, 0, 0, 1, 0, 0, 0, stl);
      // Flush overrides a pending load-use hazard
      issue(1, 0, 0, 0, 7, 1, 1, 0, 0, stl);
      issue(1, 7, 0, 0, 8, 1, 0, 1, 0, stl);
      // Freeze during a forwarded pair
      issue(1, 0, 0, 0, 3, 1, 0, 0, 0, stl);
      repeat (3) issue(1, 3, 3, 3, 4, 1, 0, 0, 1, stl);
      issue(1, 3, 3, 3, 4, 1, 0, 0, 0, stl);
      // Store source forwarding at every distance
      for (int gap = 0; gap < 4; gap++) begin
         issue(1, 0, 0, 0, 7, 1, 0, 0, 0, stl);
         repeat (gap) issue(1, 1, 2, 0, 12, 1, 0, 0, 0, stl);
         issue(1, 0, 0, 7, 0, 0, 0, 0, 0, stl);
      end
      // Store-data load-use
      issue(1, 0, 0, 0, 7, 1, 1, 0, 0, stl);
      issue(1, 1, 2, 7, 0, 0, 0, 0, 0, stl);
      issue(1, 1, 2, 7, 0, 0, 0, 0, 0, stl);
      // Pre-reset producer must not forward after reset
      issue(1, 0, 0, 0, 3, 1, 0, 0, 0, stl);
      mid_reset();
      issue(1, 3, 3, 3, 4, 1, 0, 0, 0, stl);
      // Drive stall counter into saturation
      for (int i = 0; i < 20; i++) begin
         issue(1, 0, 0, 0, 5, 1, 1, 0, 0, stl);
         issue(1, 2, 5, 0, 6, 1, 0, 0, 0, stl);
         if (stl) issue(1, 2, 5, 0, 6, 1, 0, 0, 0, stl);
      end
      mid_reset();
      // Random traffic; a stalled instruction is re-presented like a held ID stage would
      stl = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (!stl) begin
            v  = ($urandom_range(0, 9) != 0);
            s1 = $urandom_range(0, 7); s2 = $urandom_range(0, 7);
            st = $urandom_range(0, 7); d  = $urandom_range(0, 7);
            wb = ($urandom_range(0, 3) != 0); mr = ($urandom_range(0, 2) == 0);
         end
         fl = ($urandom_range(0, 15) == 0);
         fz = ($urandom_range(0, 9) == 0);
         issue(v, s1, s2, st, d, wb, mr, fl, fz, stl);
         if (fz || fl) stl = 1'b0;
      end

      for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
      @(posedge clk);
      #3;
      if (expq.size() != 0) begin
         n_err++;
         $display("FAIL drain: %0d expected entries left, required 0", expq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/forwarding_pipe.md
FORWARDING_PIPE -- requirements
Module: forwarding_pipe

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 5, register-file address width.
REQ-002 SHALL have parameter FWD_DEPTH, default 2, number of forwarding-capable downstream stages: MEM=1, WB=2, …, legal range 1..4.
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL derive localparam SEL_W = clog2(FWD_DEPTH+1) as the select width.
REQ-005 SHALL have ports in this order:
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  whole-pipeline hold.
- flush  in  1  kill instruction entering EXE.
- valid_ID  in  1  ID slot holds a real instruction.
- src1_ID, src2_ID, st_src_ID  in  ADDR_LEN  ID source registers.
- dest_ID  in  ADDR_LEN  ID destination register.
- WB_EN_ID  in  1  ID instruction writes back.
- MEM_R_EN_ID  in  1  ID instruction is a load.
- val1_sel, val2_sel, st_sel  out  SEL_W  registered EXE operand selects: 0=register file, k=stage k.
- hazard_stall  out  1  load-use stall request to PC/IF/ID.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-006 SHALL hold a tag pipeline of FWD_DEPTH+1 entries, index 0=EXE … FWD_DEPTH; each entry = {wb_en, mem_r, dest}.
REQ-007 On each clk edge with freeze=0, entry i SHALL move to i+1, the last entry SHALL be discarded, and entry 0 SHALL load the ID instruction.
REQ-008 Entry 0 SHALL load a bubble (wb_en=0, mem_r=0) when valid_ID=0, hazard_stall=1, or flush=1.
REQ-009 With freeze=1, all entries, selects and stall_cnt SHALL hold; hazard_stall SHALL still be evaluated combinationally.
REQ-010 For each ID source s, the unit SHALL compute next_sel = k+1 for the smallest k in 0..FWD_DEPTH-1 where entry k has wb_en=1, dest==s and s!=0; otherwise next_sel SHALL be 0. The nearest producer wins.
REQ-011 next_sel SHALL be registered into val1_sel/val2_sel/st_sel on edges where entry 0 loads, giving one-cycle latency aligned with EXE. Selects SHALL be 0 when entry 0 loads a bubble.
REQ-012 A producer in entry FWD_DEPTH SHALL NOT be forwarded. The register file SHALL provide write-before-read for it.
REQ-013 hazard_stall SHALL be 1 iff valid_ID=1, entry 0 has mem_r=1 and wb_en=1, its dest!=0, and its dest equals src1_ID or src2_ID, or equals st_src_ID when FWD_ST_EN is defined.
REQ-014 A stall SHALL last exactly one cycle: the bubble moves the load to MEM, the hazard clears, and the retried ID computes sel=2.
REQ-015 flush and hazard_stall together SHALL yield a single bubble. flush SHALL take precedence and SHALL NOT assert hazard_stall.
REQ-016 Register 0 SHALL never match, whatever its wb_en value.
REQ-017 stall_cnt SHALL increment on each non-frozen edge with hazard_stall=1, and SHALL saturate at 2^CNT_W-1 without wrapping.

Reset
REQ-018 While rst=0, all tag entries SHALL clear to wb_en=0, mem_r=0, dest=0; val1_sel/val2_sel/st_sel SHALL be 0; stall_cnt SHALL be 0; hazard_stall SHALL be 0.
REQ-019 Reset SHALL act mid-operation without waiting for clk. Operation SHALL resume on the first edge after rst rises.

Configuration
REQ-020 Macro FWD_ST_EN: when defined, st_sel SHALL follow REQ-010/011 for st_src_ID, and st_src_ID SHALL participate in REQ-013.
REQ-021 When FWD_ST_EN is undefined, st_sel SHALL be constant 0 and st_src_ID SHALL be ignored, including for stall detection.

Verification
REQ-022 ADD r3 in cycle n, then ADD using src1=r3 in cycle n+1: val1_sel=1 during EXE of the second instruction. With one unrelated instruction between them: val1_sel=2.
REQ-023 Instructions in consecutive cycles: ADD r3, ADD r3, then SUB with src2=r3: val2_sel=1 (nearest producer).
REQ-024 LW r5 followed by ADD with src1=r5: hazard_stall=1 for exactly one cycle, stall_cnt 0→1, bubble in EXE, then ADD in EXE with val1_sel=2.
REQ-025 Producer and consumer both use r0 with WB_EN=1: all selects 0, hazard_stall=0.
REQ-026 freeze=1 for 3 cycles during a forwarded pair: selects and entries unchanged. Pulse rst=0 mid-stream: all outputs 0 immediately, and a subsequent consumer of a pre-reset producer gets sel=0.
REQ-027 FWD_DEPTH=3, FWD_ST_EN defined: SW with st_src=r7 three cycles after ADD r7 gives st_sel=3. With FWD_ST_EN undefined, the same stimulus gives st_sel=0.
